// File: rtl/simplez_pkg.sv
// Shared constants, reply codes and loader state encoding for the Simplez core
// and its serial program loader.
package simplez_pkg;

    localparam int          SIMPLEZ_AW      = 9;
    localparam int          SIMPLEZ_DW      = 12;
    localparam logic [8:0]  SIMPLEZ_RAM_TOP = 9'h1F7;

    localparam logic [7:0]  LOADER_ACK      = 8'h4B;
    localparam logic [7:0]  LOADER_NAK      = 8'h45;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_CNT_HI,
        LD_CNT_LO,
        LD_DAT_HI,
        LD_DAT_LO,
        LD_WRITE,
        LD_CHK,
        LD_REPLY
    } loader_state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Joins a HI/LO byte pair into one RAM word with a one-cycle word_valid strobe.
// With SIMPLEZ_LOADER_CHKSUM_EN defined it also keeps the mod-256 byte sum.
module loader_word_asm
    import simplez_pkg::*;
#(
    parameter int DW = SIMPLEZ_DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_hi_we,
    input  logic          i_lo_we,
    input  logic [7:0]    i_data,
    output logic [DW-1:0] o_word,
    output logic          o_word_valid
`ifdef SIMPLEZ_LOADER_CHKSUM_EN
    ,
    input  logic          i_clr,
    output logic [7:0]    o_sum
`endif
);

    logic [DW-9:0] r_hi;
    logic [DW-1:0] r_word;
    logic          r_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hi    <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_lo_we;
            if (i_hi_we)
                r_hi <= i_data[DW-9:0];
            if (i_lo_we)
                r_word <= {r_hi, i_data};
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_valid;

`ifdef SIMPLEZ_LOADER_CHKSUM_EN
    logic [7:0] r_sum;

    // The full HI byte counts, including the nibble dropped from the word.
    always_ff @(posedge clk) begin
        if (!rstn || i_clr)
            r_sum <= '0;
        else if (i_hi_we || i_lo_we)
            r_sum <= r_sum + i_data;
    end

    assign o_sum = r_sum;
`endif

endmodule

// File: rtl/simplez_loader.sv
// Serial program loader: parses SYNC/count/words[/checksum] frames, writes the
// Simplez RAM and replies K/E. Checksum byte enabled by SIMPLEZ_LOADER_CHKSUM_EN.
module simplez_loader
    import simplez_pkg::*;
#(
    parameter int         AW        = SIMPLEZ_AW,
    parameter int         DW        = SIMPLEZ_DW,
    parameter logic [7:0] SYNC      = 8'h53,
    parameter int         MAX_WORDS = int'(SIMPLEZ_RAM_TOP) + 1,
    parameter logic       BOOT_RUN  = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    rx_data,
    input  logic          rx_rcv,
    input  logic          tx_ready,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          ram_cs,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          err
);

    localparam logic [9:0] LP_MAX = 10'(MAX_WORDS);

    loader_state_t r_state;
    logic          r_cnt_hi;
    logic [8:0]    r_count;
    logic [8:0]    r_index;
    logic          r_ack;
    logic          r_tx_start;
    logic [7:0]    r_tx_data;
    logic          r_cpu_rstn;
    logic          r_err;

    logic          w_hi_we;
    logic          w_lo_we;
    logic [8:0]    w_n;
    logic          w_bad_cnt;
    logic          w_last;
    logic [DW-1:0] w_word;
    logic          w_word_valid;

    assign w_hi_we   = rx_rcv && (r_state == LD_DAT_HI);
    assign w_lo_we   = rx_rcv && (r_state == LD_DAT_LO);
    assign w_n       = {r_cnt_hi, rx_data};
    assign w_bad_cnt = (w_n == 9'd0) || ({1'b0, w_n} > LP_MAX);
    assign w_last    = (r_index == r_count - 9'd1);

`ifdef SIMPLEZ_LOADER_CHKSUM_EN
    logic       w_clr;
    logic [7:0] w_sum;

    assign w_clr = rx_rcv && (r_state == LD_IDLE) && (rx_data == SYNC);
`endif

    loader_word_asm #(
        .DW           (DW)
    ) u_word_asm (
        .clk          (clk),
        .rstn         (rstn),
        .i_hi_we      (w_hi_we),
        .i_lo_we      (w_lo_we),
        .i_data       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
`ifdef SIMPLEZ_LOADER_CHKSUM_EN
        ,
        .i_clr        (w_clr),
        .o_sum        (w_sum)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= LD_IDLE;
            r_cnt_hi   <= 1'b0;
            r_count    <= '0;
            r_index    <= '0;
            r_ack      <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_cpu_rstn <= BOOT_RUN;
            r_err      <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                LD_IDLE: begin
                    if (rx_rcv && rx_data == SYNC) begin
                        r_state    <= LD_CNT_HI;
                        r_cpu_rstn <= 1'b0;
                        r_err      <= 1'b0;
                        r_index    <= '0;
                    end
                end
                LD_CNT_HI: begin
                    if (rx_rcv) begin
                        r_cnt_hi <= rx_data[0];
                        r_state  <= LD_CNT_LO;
                    end
                end
                LD_CNT_LO: begin
                    if (rx_rcv) begin
                        r_count <= w_n;
                        if (w_bad_cnt) begin
                            r_state   <= LD_REPLY;
                            r_tx_data <= LOADER_NAK;
                            r_ack     <= 1'b0;
                            r_err     <= 1'b1;
                        end else begin
                            r_state <= LD_DAT_HI;
                        end
                    end
                end
                LD_DAT_HI: begin
                    if (rx_rcv)
                        r_state <= LD_DAT_LO;
                end
                LD_DAT_LO: begin
                    if (rx_rcv)
                        r_state <= LD_WRITE;
                end
                LD_WRITE: begin
                    r_index <= r_index + 9'd1;
                    if (!w_last) begin
                        r_state <= LD_DAT_HI;
                    end else begin
`ifdef SIMPLEZ_LOADER_CHKSUM_EN
                        r_state <= LD_CHK;
`else
                        r_state   <= LD_REPLY;
                        r_tx_data <= LOADER_ACK;
                        r_ack     <= 1'b1;
`endif
                    end
                end
                LD_CHK: begin
`ifdef SIMPLEZ_LOADER_CHKSUM_EN
                    if (rx_rcv) begin
                        r_state <= LD_REPLY;
                        if (rx_data == w_sum) begin
                            r_tx_data <= LOADER_ACK;
                            r_ack     <= 1'b1;
                        end else begin
                            r_tx_data <= LOADER_NAK;
                            r_ack     <= 1'b0;
                            r_err     <= 1'b1;
                        end
                    end
`else
                    r_state <= LD_IDLE;
`endif
                end
                LD_REPLY: begin
                    // Release the CPU together with the ACK strobe.
                    if (tx_ready) begin
                        r_tx_start <= 1'b1;
                        if (r_ack)
                            r_cpu_rstn <= 1'b1;
                        r_state <= LD_IDLE;
                    end
                end
                default: r_state <= LD_IDLE;
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign cpu_rstn = r_cpu_rstn;
    assign err      = r_err;
    assign busy     = (r_state != LD_IDLE);
    assign ram_cs   = w_word_valid;
    assign ram_rw   = ~w_word_valid;
    assign ram_addr = AW'(r_index);
    assign ram_din  = w_word;

endmodule

// File: tb/tb_simplez_loader.sv
// Randomized frame-level bench for simplez_loader against a word/reply model.
// Honours SIMPLEZ_LOADER_CHKSUM_EN for the optional checksum byte.
module tb_simplez_loader;

    localparam int MAXW = 504;
`ifdef SIMPLEZ_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rcv = 1'b0;
    logic        tx_ready = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        ram_cs;
    logic        ram_rw;
    logic [8:0]  ram_addr;
    logic [11:0] ram_din;
    logic        cpu_rstn;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    simplez_loader #(
        .BOOT_RUN (1'b1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_rcv   (rx_rcv),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .ram_cs   (ram_cs),
        .ram_rw   (ram_rw),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .err      (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: expected RAM image and the words of the next frame.
    int dut_mem [512];
    int ref_mem [512];
    int wd      [512];
    int hi_top  [512];

    int         wr_cnt = 0;
    int         wr_idx = 0;
    int         last_addr = -1;
    int         tx_cnt = 0;
    logic [7:0] tx_last = 8'h00;
    logic       tx_cpu = 1'b0;
    logic       rcv_q = 1'b0;

    always @(posedge clk) rcv_q <= rx_rcv;

    always @(negedge clk) begin
        if (ram_cs) begin
            check("wr_rw", ram_rw, 0);
            check("wr_latency", rcv_q, 1);
            check("wr_addr", ram_addr, wr_idx);
            dut_mem[ram_addr] = ram_din;
            last_addr = ram_addr;
            wr_idx++;
            wr_cnt++;
        end
        if (tx_start) begin
            tx_cnt++;
            tx_last = tx_data;
            tx_cpu  = cpu_rstn;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rcv  = 1'b1;
        @(negedge clk);
        rx_rcv  = 1'b0;
        rx_data = 8'($urandom);
        repeat ($urandom_range(2, 0)) @(negedge clk);
    endtask

    task automatic mem_compare(input string tag);
        int d = 0;
        for (int a = 0; a < 512; a++)
            if (dut_mem[a] != ref_mem[a]) d++;
        check(tag, d, 0);
    endtask

    task automatic fill_words(input int n);
        for (int i = 0; i < n; i++) begin
            wd[i]     = int'($urandom_range(4095, 0));
            hi_top[i] = int'($urandom_range(15, 0));
        end
    endtask

    // stop_words >= 0 sends only that many words and returns (truncated frame).
    task automatic run_frame(input int n, input bit bad, input int stop_words, input bit slow_tx);
        logic [7:0] hb, lb, sum;
        bit   legal, ack;
        int   nw, w0, t0;
        logic [8:0] nn;
        legal  = (n >= 1) && (n <= MAXW);
        ack    = legal && !(CHK_EN && bad);
        nn     = 9'(n);
        w0     = wr_cnt;
        t0     = tx_cnt;
        wr_idx = 0;
        sum    = 8'h00;
        nw     = (stop_words >= 0) ? stop_words : (legal ? n : 0);
        tx_ready = !slow_tx;

        send_byte(8'h53);
        check("sync_busy", busy, 1);
        check("sync_cpu_rstn", cpu_rstn, 0);
        check("sync_err", err, 0);
        send_byte({7'($urandom), nn[8]});
        send_byte(nn[7:0]);
        for (int i = 0; i < nw; i++) begin
            hb  = {4'(hi_top[i]), 4'(wd[i] >> 8)};
            lb  = 8'(wd[i]);
            sum = sum + hb + lb;
            ref_mem[i] = wd[i];
            send_byte(hb);
            send_byte(lb);
        end
        if (stop_words >= 0) return;
`ifdef SIMPLEZ_LOADER_CHKSUM_EN
        if (legal) send_byte(bad ? sum + 8'h01 : sum);
`endif
        if (slow_tx) begin
            repeat (100) @(posedge clk);
            check("held_no_tx", tx_cnt - t0, 0);
            check("held_busy", busy, 1);
            tx_ready = 1'b1;
        end
        for (int i = 0; i < 64 && tx_cnt == t0; i++) @(posedge clk);
        repeat (3) @(negedge clk);
        check("reply_pulses", tx_cnt - t0, 1);
        check("reply_code", tx_last, ack ? 8'h4B : 8'h45);
        check("reply_cpu_rstn", tx_cpu, ack);
        check("cpu_rstn_after", cpu_rstn, ack);
        check("err_after", err, !ack);
        check("busy_after", busy, 0);
        check("tx_data_hold", tx_data, ack ? 8'h4B : 8'h45);
        check("write_count", wr_cnt - w0, nw);
        mem_compare("ram_image");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, t0;
        logic [7:0] g;
        for (int a = 0; a < 512; a++) begin
            dut_mem[a] = -1;
            ref_mem[a] = -1;
        end

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_cpu_rstn", cpu_rstn, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ram_cs", ram_cs, 0);
        check("rst_ram_rw", ram_rw, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);

        // Reference frame: 0x123, 0xE00, checksum 0x32.
        wd[0] = 12'h123; hi_top[0] = 0;
        wd[1] = 12'hE00; hi_top[1] = 0;
        run_frame(2, 1'b0, -1, 1'b0);
`ifdef SIMPLEZ_LOADER_CHKSUM_EN
        run_frame(2, 1'b1, -1, 1'b0);
        run_frame(2, 1'b0, -1, 1'b0);
`endif

        fill_words(MAXW);
        run_frame(MAXW, 1'b0, -1, 1'b0);
        check("last_addr", last_addr, 32'h1F7);
        run_frame(MAXW + 1, 1'b0, -1, 1'b0);
        run_frame(0, 1'b0, -1, 1'b0);

        w0 = wr_cnt;
        t0 = tx_cnt;
        send_byte(8'h41); check("idle_41_busy", busy, 0);
        send_byte(8'h00); check("idle_00_busy", busy, 0);
        send_byte(8'hFF); check("idle_FF_busy", busy, 0);
        check("idle_no_tx", tx_cnt - t0, 0);
        check("idle_no_wr", wr_cnt - w0, 0);

        fill_words(3);
        run_frame(3, 1'b0, -1, 1'b1);

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(7, 0))
                0:       n = int'($urandom_range(511, MAXW + 1));
                1:       n = 0;
                default: n = int'($urandom_range(12, 1));
            endcase
            repeat ($urandom_range(3, 0)) begin
                g = 8'($urandom);
                if (g == 8'h53) g = 8'h54;
                send_byte(g);
            end
            fill_words(12);
            run_frame(n, ($urandom_range(2, 0) == 0), -1, 1'b0);
        end

        // Reset after 3 of 5 words: words 0-2 land, 3-4 keep their old contents.
        fill_words(5);
        w0 = wr_cnt;
        t0 = tx_cnt;
        run_frame(5, 1'b0, 3, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_cpu_rstn", cpu_rstn, 1);
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        check("midrst_no_tx", tx_cnt - t0, 0);
        check("midrst_writes", wr_cnt - w0, 3);
        mem_compare("midrst_ram");

        fill_words(4);
        run_frame(4, 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
